// File: rtl/vec_mul_pkg.sv
// Shared types and default sizing for the 1x64 vector-multiply control path.
// The top level takes its parameter defaults from here.
package vec_mul_pkg;

  localparam int ADDRESSSIZE_DEF   = 10;
  localparam int COUNT_BW_DEF      = 10;
  localparam int PIPE_LATENCY_DEF  = 2;
  localparam int RELOAD_CYCLES_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_W = 3'd1,
    ST_POP    = 3'd2,
    ST_RELOAD = 3'd3,
    ST_STREAM = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/valid_delay_line.sv
// Shift register that aligns the UB read-valid with the datapath output,
// so the result write strobe lands on the cycle the product is ready.
module valid_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stage;

  // NOTE: the stages must be cleared on reset; an abort has to drop
  // reads already in flight so no stray write reaches the Results SRAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vec_mul_sequencer.sv
// Job sequencer for the vector-multiply datapath: weight pop and reload,
// UB address streaming, and latency-aligned Results SRAM writes.
module vec_mul_sequencer
  import vec_mul_pkg::*;
#(
  parameter int ADDRESSSIZE   = ADDRESSSIZE_DEF,
  parameter int COUNT_BW      = COUNT_BW_DEF,
  parameter int PIPE_LATENCY  = PIPE_LATENCY_DEF,
  parameter int RELOAD_CYCLES = RELOAD_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] src_base,
  input  logic [ADDRESSSIZE-1:0] dst_base,
  input  logic [COUNT_BW-1:0]    num_vec,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   weight_reload,
  output logic [ADDRESSSIZE-1:0] ub_address,
  output logic                   ub_read_valid,
  output logic                   res_write_enable,
  output logic [ADDRESSSIZE-1:0] res_address,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int RLW = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;
  localparam logic [RLW-1:0] RL_LAST = RLW'(RELOAD_CYCLES - 1);

  state_t              state;
  logic [COUNT_BW-1:0] num_q;
  logic [COUNT_BW-1:0] rd_cnt;
  logic [COUNT_BW-1:0] wr_cnt;
  logic [RLW-1:0]      rl_cnt;

  valid_delay_line #(
    .DEPTH (PIPE_LATENCY)
  ) u_valid_delay (
    .clk (clk),
    .rst (rst),
    .d   (ub_read_valid),
    .q   (res_write_enable)
  );

  // NOTE: state and every output are registers updated only with <=, so
  // all of them change together on the clock edge and nothing is a latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      num_q            <= '0;
      rd_cnt           <= '0;
      wr_cnt           <= '0;
      rl_cnt           <= '0;
      fifo_read_enable <= 1'b0;
      weight_reload    <= 1'b0;
      ub_address       <= '0;
      ub_read_valid    <= 1'b0;
      res_address      <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      // Write address advances only on an actual write, independent of state.
      if (res_write_enable) begin
        res_address <= res_address + 1'b1;
        wr_cnt      <= wr_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_vec == '0) begin
              err <= 1'b1;
            end else begin
              num_q       <= num_vec;
              ub_address  <= src_base;
              res_address <= dst_base;
              rd_cnt      <= '0;
              wr_cnt      <= '0;
              err         <= 1'b0;
              busy        <= 1'b1;
              state       <= ST_WAIT_W;
            end
          end
        end

        ST_WAIT_W: begin
          if (!fifo_empty) begin
            fifo_read_enable <= 1'b1;
            state            <= ST_POP;
          end
        end

        ST_POP: begin
          fifo_read_enable <= 1'b0;
          weight_reload    <= 1'b1;
          rl_cnt           <= '0;
          state            <= ST_RELOAD;
        end

        ST_RELOAD: begin
          if (rl_cnt == RL_LAST) begin
            weight_reload <= 1'b0;
            ub_read_valid <= 1'b1;
            rd_cnt        <= COUNT_BW'(1);
            state         <= ST_STREAM;
          end else begin
            rl_cnt <= rl_cnt + 1'b1;
          end
        end

        // rd_cnt counts reads already presented, including the current one.
        ST_STREAM: begin
          if (rd_cnt == num_q) begin
            ub_read_valid <= 1'b0;
            state         <= ST_DRAIN;
          end else begin
            ub_address <= ub_address + 1'b1;
            rd_cnt     <= rd_cnt + 1'b1;
          end
        end

        // Leave on the final write so done follows it by exactly one cycle.
        ST_DRAIN: begin
          if (res_write_enable && (wr_cnt == num_q - 1'b1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
